// File: rtl/stack_pkg.sv
// Command and FSM encodings shared by the stack driver slice.
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_OUT,
    ST_GET,
    ST_GWAIT,
    ST_GOUT
  } state_t;

endpackage

// File: rtl/stack_driver_if.sv
// Write-in and read-out valid/ready streams of the stack driver.
interface stack_driver_if #(
  parameter int DATA_W = 4
);
  import stack_pkg::*;

  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;

  modport master (
    output IN_VALID, IN_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA
  );

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA
  );
endinterface

// File: rtl/stack_driver_rst_bridge.sv
// Turns the active-low system reset into the stack's active-high reset,
// stretched for one full clock cycle after release.
module stack_driver_rst_bridge (
  input  logic clk,
  input  logic rst_n,
  output logic s_reset
);
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      s_reset <= 1'b1;
    end else begin
      armed   <= 1'b1;
      s_reset <= !armed;
    end
  end
endmodule

// File: rtl/stack_driver.sv
// Command-side initiator for the stack: push stream in, LIFO drain out.
// Indexed peek (GET) is built only with STACK_DRIVER_PEEK_EN defined.
module stack_driver
  import stack_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 3,
  parameter int DEPTH  = 5,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  stack_driver_if.slave     io,
  input  logic              DRAIN,
  input  logic              PEEK_REQ,
  input  logic [IDX_W-1:0]  PEEK_IDX,
  output logic              DONE,
  output logic [IDX_W-1:0]  COUNT,
  output logic              BUSY,
  output logic              S_RESET,
  output logic [1:0]        S_COMMAND,
  output logic [IDX_W-1:0]  S_INDEX,
  output logic [DATA_W-1:0] S_I_DATA,
  input  logic [DATA_W-1:0] S_O_DATA
);
  localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] ONE_C   = IDX_W'(1);
  localparam logic [1:0]       LAT_C   = 2'(RD_LAT - 1);

  state_t            state;
  cmd_t              cmd;
  logic [IDX_W-1:0]  count;
  logic [1:0]        wcnt;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              done;
  logic [IDX_W-1:0]  s_index;
  logic [DATA_W-1:0] s_i_data;
  logic              s_reset;
  logic              in_ready;

  stack_driver_rst_bridge u_rst (
    .clk     (CLK),
    .rst_n   (RESET),
    .s_reset (s_reset)
  );

`ifdef STACK_DRIVER_PEEK_EN
  assign in_ready = (state == ST_IDLE) && !DRAIN && !PEEK_REQ &&
                    (count < DEPTH_C) && !s_reset;
`else
  logic unused_peek;
  assign unused_peek = ^{PEEK_REQ, PEEK_IDX};
  assign in_ready = (state == ST_IDLE) && !DRAIN &&
                    (count < DEPTH_C) && !s_reset;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      cmd       <= CMD_NOP;
      count     <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      s_index   <= '0;
      s_i_data  <= '0;
    end else begin
      cmd  <= CMD_NOP;
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (s_reset) begin
            state <= ST_IDLE;
          end else if (DRAIN) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_POP;
              cmd   <= CMD_POP;
            end
          end
`ifdef STACK_DRIVER_PEEK_EN
          else if (PEEK_REQ) begin
            if (PEEK_IDX < count) begin
              state   <= ST_GET;
              cmd     <= CMD_GET;
              s_index <= PEEK_IDX;
            end else begin
              state     <= ST_GOUT;
              out_valid <= 1'b1;
              out_data  <= '0;
            end
          end
`endif
          else if (io.IN_VALID && in_ready) begin
            cmd      <= CMD_PUSH;
            s_i_data <= io.IN_DATA;
            count    <= count + 1'b1;
          end
        end
        ST_POP: begin
          state <= ST_WAIT;
          wcnt  <= LAT_C;
        end
        ST_WAIT: begin
          if (wcnt == '0) begin
            state     <= ST_OUT;
            out_valid <= 1'b1;
            out_data  <= S_O_DATA;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        // A fresh POP only leaves once the consumer has taken this word
        ST_OUT: begin
          if (io.OUT_READY) begin
            out_valid <= 1'b0;
            count     <= count - 1'b1;
            if (count != ONE_C) begin
              state <= ST_POP;
              cmd   <= CMD_POP;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
`ifdef STACK_DRIVER_PEEK_EN
        ST_GET: begin
          state <= ST_GWAIT;
          wcnt  <= LAT_C;
        end
        ST_GWAIT: begin
          if (wcnt == '0) begin
            state     <= ST_GOUT;
            out_valid <= 1'b1;
            out_data  <= S_O_DATA;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        ST_GOUT: begin
          if (io.OUT_READY) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.IN_READY  = in_ready;
  assign io.OUT_VALID = out_valid;
  assign io.OUT_DATA  = out_data;
  assign DONE         = done;
  assign COUNT        = count;
  assign BUSY         = (state != ST_IDLE);
  assign S_RESET      = s_reset;
  assign S_COMMAND    = cmd;
  assign S_INDEX      = s_index;
  assign S_I_DATA     = s_i_data;
endmodule

// File: tb/tb_stack_driver.sv
// Directed bench for stack_driver with a behavioural stack model.
module tb_stack_driver;
  import stack_pkg::*;

  localparam int DATA_W = 4;
  localparam int IDX_W  = 3;
  localparam int DEPTH  = 5;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              drain = 1'b0;
  logic              peek_req = 1'b0;
  logic [IDX_W-1:0]  peek_idx = '0;
  logic              done;
  logic [IDX_W-1:0]  count;
  logic              busy;
  logic              s_reset;
  logic [1:0]        s_command;
  logic [IDX_W-1:0]  s_index;
  logic [DATA_W-1:0] s_i_data;
  logic [DATA_W-1:0] s_o_data = '0;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_pop  = 0;
  int n_get  = 0;

  logic [DATA_W-1:0] mem [0:7];
  int sp = 0;

  stack_driver_if #(.DATA_W(DATA_W)) io ();

  stack_driver #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .io        (io),
    .DRAIN     (drain),
    .PEEK_REQ  (peek_req),
    .PEEK_IDX  (peek_idx),
    .DONE      (done),
    .COUNT     (count),
    .BUSY      (busy),
    .S_RESET   (s_reset),
    .S_COMMAND (s_command),
    .S_INDEX   (s_index),
    .S_I_DATA  (s_i_data),
    .S_O_DATA  (s_o_data)
  );

  always #5 clk = ~clk;

  // Stack model: registered read data, one cycle after the command edge
  always @(posedge clk) begin
    if (s_reset) begin
      sp       <= 0;
      s_o_data <= '0;
    end else begin
      case (s_command)
        2'b01: begin
          if (sp < 8) mem[sp] <= s_i_data;
          sp <= sp + 1;
        end
        2'b10: begin
          if (sp > 0) s_o_data <= mem[sp-1];
          sp <= sp - 1;
        end
        2'b11: begin
          if (sp - 1 - int'(s_index) >= 0)
            s_o_data <= mem[sp-1-int'(s_index)];
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (s_command == 2'b01) n_push <= n_push + 1;
    if (s_command == 2'b10) n_pop  <= n_pop + 1;
    if (s_command == 2'b11) n_get  <= n_get + 1;
  end

  task automatic push_words(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      io.IN_VALID = 1'b1;
      io.IN_DATA  = DATA_W'(first + i);
      @(negedge clk);
    end
    io.IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io.IN_VALID = 1'b1;
    io.IN_DATA  = 4'd9;
    repeat (2) @(negedge clk);
    checks++;
    if (s_reset !== 1'b1 || count !== 3'd0 || io.OUT_VALID !== 1'b0 ||
        io.OUT_DATA !== 4'd0 || done !== 1'b0 || s_command !== 2'b00 ||
        s_index !== 3'd0 || s_i_data !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: s_reset=%b count=%0d ov=%b od=%0d done=%b cmd=%0d idx=%0d idata=%0d busy=%b, want 1 0 0 0 0 0 0 0 0",
               s_reset, count, io.OUT_VALID, io.OUT_DATA, done, s_command, s_index, s_i_data, busy);
    end
    checks++;
    if (io.IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", io.IN_READY);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_reset !== 1'b1 || io.IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL reset_stretch: s_reset=%b in_ready=%b want 1 0", s_reset, io.IN_READY);
    end
    @(negedge clk);
    checks++;
    if (s_reset !== 1'b0 || count !== 3'd0 || n_push != 0) begin
      errors++;
      $display("FAIL reset_release: s_reset=%b count=%0d pushes=%0d want 0 0 0", s_reset, count, n_push);
    end
    io.IN_VALID = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      io.IN_VALID = 1'b1;
      io.IN_DATA  = DATA_W'(i);
      #1;
      checks++;
      if (io.IN_READY !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready[%0d]: got %b want 1", i, io.IN_READY);
      end
      @(negedge clk);
      checks++;
      if (s_command !== CMD_PUSH || s_i_data !== DATA_W'(i) || count !== IDX_W'(i)) begin
        errors++;
        $display("FAIL fill_push[%0d]: cmd=%0d data=%0d count=%0d want 1 %0d %0d", i, s_command, s_i_data, count, i, i);
      end
    end
    io.IN_DATA = 4'd6;
    #1;
    checks++;
    if (io.IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL fill_full_ready: got %b want 0", io.IN_READY);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (s_command !== CMD_NOP || count !== 3'd5 || n_push != 5) begin
      errors++;
      $display("FAIL fill_overflow: cmd=%0d count=%0d pushes=%0d want 0 5 5", s_command, count, n_push);
    end
    io.IN_VALID = 1'b0;
  endtask

  task automatic test_drain();
    logic [DATA_W-1:0] got[$];
    int at[$];
    int dones = 0;
    int done_at = -1;
    int pop0 = n_pop;
    io.OUT_READY = 1'b1;
    drain = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      drain = 1'b0;
      if (io.OUT_VALID === 1'b1) begin
        got.push_back(io.OUT_DATA);
        at.push_back(c);
      end
      if (done === 1'b1) begin
        dones++;
        done_at = c;
      end
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL drain_words: got %0d words want 5", got.size());
    end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== DATA_W'(5 - k) || at[k] != 2 + 3 * k) begin
        errors++;
        $display("FAIL drain_word[%0d]: data=%0d cycle=%0d want %0d %0d", k, got[k], at[k], 5 - k, 2 + 3 * k);
      end
    end
    checks++;
    if (dones != 1 || done_at != 15 || count !== 3'd0 || busy !== 1'b0 || n_pop - pop0 != 5) begin
      errors++;
      $display("FAIL drain_done: pulses=%0d at=%0d count=%0d busy=%b pops=%0d want 1 15 0 0 5",
               dones, done_at, count, busy, n_pop - pop0);
    end
  endtask

  task automatic test_backpressure();
    bit ok = 1'b0;
    int pop0;
    push_words(5, 1);
    pop0 = n_pop;
    io.OUT_READY = 1'b0;
    drain = 1'b1;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      drain = 1'b0;
      ok = (io.OUT_VALID === 1'b1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_first_valid: timeout, out_valid=%b want 1", io.OUT_VALID);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (io.OUT_VALID !== 1'b1 || io.OUT_DATA !== 4'd5 || n_pop != pop0 + 1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: ov=%b data=%0d pops=%0d want 1 5 1", c, io.OUT_VALID, io.OUT_DATA, n_pop - pop0);
      end
      if (c < 4) @(negedge clk);
    end
    io.OUT_READY = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      ok = (done === 1'b1);
    end
    checks++;
    if (!ok || count !== 3'd0 || n_pop != pop0 + 5) begin
      errors++;
      $display("FAIL bp_complete: done_seen=%b count=%0d pops=%0d want 1 0 5", ok, count, n_pop - pop0);
    end
  endtask

  task automatic test_empty_drain();
    int pop0 = n_pop;
    drain = 1'b1;
    @(negedge clk);
    drain = 1'b0;
    checks++;
    if (done !== 1'b1 || s_command !== CMD_NOP || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_drain: done=%b cmd=%0d busy=%b want 1 0 0", done, s_command, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || n_pop != pop0) begin
      errors++;
      $display("FAIL empty_drain_after: done=%b pops=%0d want 0 0", done, n_pop - pop0);
    end
  endtask

`ifdef STACK_DRIVER_PEEK_EN
  task automatic test_peek();
    bit ok = 1'b0;
    int get0;
    push_words(3, 1);
    get0 = n_get;
    io.OUT_READY = 1'b0;
    peek_req = 1'b1;
    peek_idx = 3'd0;
    #1;
    checks++;
    if (io.IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL peek_in_ready: got %b want 0", io.IN_READY);
    end
    @(negedge clk);
    peek_req = 1'b0;
    checks++;
    if (s_command !== CMD_GET || s_index !== 3'd0) begin
      errors++;
      $display("FAIL peek_get: cmd=%0d idx=%0d want 3 0", s_command, s_index);
    end
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      ok = (io.OUT_VALID === 1'b1);
    end
    checks++;
    if (!ok || io.OUT_DATA !== 4'd3 || count !== 3'd3 || n_get != get0 + 1) begin
      errors++;
      $display("FAIL peek_data: valid=%b data=%0d count=%0d gets=%0d want 1 3 3 1", ok, io.OUT_DATA, count, n_get - get0);
    end
    io.OUT_READY = 1'b1;
    @(negedge clk);
    checks++;
    if (io.OUT_VALID !== 1'b0 || busy !== 1'b0 || count !== 3'd3) begin
      errors++;
      $display("FAIL peek_release: ov=%b busy=%b count=%0d want 0 0 3", io.OUT_VALID, busy, count);
    end
    peek_req = 1'b1;
    peek_idx = 3'd4;
    @(negedge clk);
    peek_req = 1'b0;
    checks++;
    if (io.OUT_VALID !== 1'b1 || io.OUT_DATA !== 4'd0 || s_command !== CMD_NOP) begin
      errors++;
      $display("FAIL peek_oob: ov=%b data=%0d cmd=%0d want 1 0 0", io.OUT_VALID, io.OUT_DATA, s_command);
    end
    @(negedge clk);
    checks++;
    if (io.OUT_VALID !== 1'b0 || n_get != get0 + 1 || count !== 3'd3) begin
      errors++;
      $display("FAIL peek_oob_after: ov=%b gets=%0d count=%0d want 0 1 3", io.OUT_VALID, n_get - get0, count);
    end
  endtask
`else
  task automatic test_peek_ignored();
    peek_req = 1'b1;
    peek_idx = 3'd0;
    io.IN_VALID = 1'b1;
    io.IN_DATA  = 4'd7;
    #1;
    checks++;
    if (io.IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL peek_off_ready: got %b want 1", io.IN_READY);
    end
    @(negedge clk);
    io.IN_VALID = 1'b0;
    peek_req = 1'b0;
    checks++;
    if (s_command !== CMD_PUSH || count !== 3'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL peek_off_push: cmd=%0d count=%0d busy=%b want 1 1 0", s_command, count, busy);
    end
    @(negedge clk);
    checks++;
    if (n_get != 0) begin
      errors++;
      $display("FAIL peek_off_get: gets=%0d want 0", n_get);
    end
  endtask
`endif

  task automatic test_reset_mid_drain();
    bit ok = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_words(4, 10);
    io.OUT_READY = 1'b0;
    drain = 1'b1;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      drain = 1'b0;
      ok = (io.OUT_VALID === 1'b1);
    end
    checks++;
    if (!ok || io.OUT_DATA !== 4'd13) begin
      errors++;
      $display("FAIL mid_first_word: valid=%b data=%0d want 1 13", ok, io.OUT_DATA);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || io.OUT_VALID !== 1'b0 || s_reset !== 1'b1 ||
        busy !== 1'b0 || io.OUT_DATA !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d ov=%b s_reset=%b busy=%b od=%0d want 0 0 1 0 0",
               count, io.OUT_VALID, s_reset, busy, io.OUT_DATA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_reset !== 1'b0 || count !== 3'd0 || sp != 0) begin
      errors++;
      $display("FAIL mid_recover: s_reset=%b count=%0d stack_sp=%0d want 0 0 0", s_reset, count, sp);
    end
  endtask

  initial begin
    io.IN_VALID  = 1'b0;
    io.IN_DATA   = '0;
    io.OUT_READY = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_backpressure();
    test_empty_drain();
`ifdef STACK_DRIVER_PEEK_EN
    test_peek();
`else
    test_peek_ignored();
`endif
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_driver.md
Name: stack_driver

Overview:
- Command-side initiator for the stack_structural_lite command bus (NOP/PUSH/POP/GET).
- Accepts a valid/ready write stream and pushes each word onto the stack.
- On a drain request, pops every stored word and streams it out in LIFO order. An optional path reads an entry by index (GET) without popping it.
- Sits between producer/consumer logic and the stack, and bridges the system reset to the stack's active-high reset.

Parameters:
DATA_W, 4, word width (matches stack I_DATA/O_DATA)
IDX_W, 3, stack INDEX width
DEPTH, 5, stack capacity in words
RD_LAT, 1, cycles from POP/GET issue edge to valid S_O_DATA (1..3)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low
IN_VALID  in  1  write word offered
IN_READY  out  1  write word accepted when IN_VALID&&IN_READY at CLK edge
IN_DATA  in  DATA_W  word to push
DRAIN  in  1  level; sampled in IDLE; starts pop-all
PEEK_REQ  in  1  request GET (feature-gated)
PEEK_IDX  in  IDX_W  GET index, 0 = top of stack
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  consumer accepts OUT_DATA
OUT_DATA  out  DATA_W  popped/peeked word
DONE  out  1  one-cycle pulse when drain completes
COUNT  out  IDX_W  words currently stored (0..DEPTH)
BUSY  out  1  state != IDLE
S_RESET  out  1  active-high reset to stack
S_COMMAND  out  2  00 NOP, 01 PUSH, 10 POP, 11 GET
S_INDEX  out  IDX_W  GET index
S_I_DATA  out  DATA_W  PUSH data
S_O_DATA  in  DATA_W  stack read data

Behaviour:
- Reset (RESET=0, async): state IDLE; COUNT=0; OUT_VALID=0; OUT_DATA=0; DONE=0; S_COMMAND=NOP; S_INDEX=0; S_I_DATA=0; S_RESET=1.
- S_RESET stays 1 while RESET=0 and for exactly one CLK cycle after deassertion. All handshakes are blocked (IN_READY=0) during that cycle.
- All S_* outputs and OUT_* outputs are registered. S_COMMAND is NOP unless stated below.
- FSM states: IDLE, POP, WAIT, OUT, GET, GWAIT, GOUT.
- IDLE priority at each edge:
  - DRAIN beats PEEK_REQ beats IN_VALID.
  - IN_READY = IDLE && !DRAIN && !PEEK_REQ && COUNT<DEPTH && !S_RESET.
- PUSH:
  - Acceptance at edge t sets S_COMMAND=PUSH and S_I_DATA=IN_DATA for cycle t..t+1, and increments COUNT.
  - Back-to-back pushes are allowed, one per cycle.
  - At COUNT==DEPTH, IN_READY=0; no overflow PUSH is ever issued.
- DRAIN in IDLE with COUNT==0: DONE pulses on the next cycle, no stack commands are issued, and the FSM stays in IDLE.
- DRAIN in IDLE with COUNT>0:
  - POP: S_COMMAND=POP for one cycle.
  - WAIT: RD_LAT cycles.
  - Capture S_O_DATA into OUT_DATA and set OUT_VALID=1 (state OUT).
  - OUT: hold OUT_DATA and OUT_VALID stable until OUT_READY. On the handshake edge, COUNT decrements and OUT_VALID drops.
  - If the new COUNT>0, go to POP; otherwise pulse DONE and go to IDLE.
- DRAIN is sampled only in IDLE; deasserting it mid-drain has no effect.
- Output order is LIFO.
- No new POP is issued while OUT_VALID=1 (backpressure stalls the stack).
- Reset mid-operation aborts immediately. The in-flight word is lost, COUNT returns to 0, and the stack is cleared via S_RESET.

Optional Feature:
- Macro: STACK_DRIVER_PEEK_EN.
- Defined:
  - PEEK_REQ in IDLE with PEEK_IDX<COUNT enters GET: S_COMMAND=GET and S_INDEX=PEEK_IDX for one cycle.
  - GWAIT: RD_LAT cycles.
  - GOUT: OUT_VALID=1 with the peeked word until OUT_READY, then IDLE. COUNT is unchanged.
  - PEEK_IDX>=COUNT returns OUT_DATA=0 with OUT_VALID=1 and issues no GET.
- Undefined: PEEK_REQ and PEEK_IDX are ignored, the GET/GWAIT/GOUT states and logic are absent, and S_COMMAND never equals GET.
- IN_READY does not depend on PEEK_REQ when the macro is undefined.

Decomposition:
- Package stack_pkg: cmd_t enum (CMD_NOP=2'b00, CMD_PUSH=2'b01, CMD_POP=2'b10, CMD_GET=2'b11) and state_t enum.
- Only the enums go in the package; default widths are carried by the parameters.
- One sub-module: stack_driver_rst_bridge, which generates S_RESET and the one-cycle post-reset block.

Test Plan:
- Reset sequence: RESET=0 for 2 cycles, then 1 → S_RESET=1 through one cycle after release, IN_READY=0 during it, all outputs 0, COUNT=0.
- Push 1,2,3,4,5 back-to-back → S_COMMAND=PUSH five consecutive cycles with S_I_DATA=1..5, COUNT=5, IN_READY=0. A sixth word (6) is never issued.
- DRAIN after the fill, OUT_READY=1 → OUT_DATA sequence 5,4,3,2,1, then DONE pulses once and COUNT=0. Each word takes RD_LAT+2 cycles.
- DRAIN with OUT_READY=0 for 4 cycles on the first word → OUT_DATA=5 stays stable and no second POP is issued until the handshake.
- DRAIN with COUNT=0 → DONE pulse next cycle, S_COMMAND stays NOP.
- With STACK_DRIVER_PEEK_EN defined:
  - Push 1,2,3, then PEEK_IDX=0 → GET with S_INDEX=0 and OUT_DATA=3; COUNT stays 3.
  - Then PEEK_IDX=4 → OUT_DATA=0 and no GET is issued.
  - Then assert RESET=0 mid-drain → COUNT=0, OUT_VALID=0, S_RESET=1.
